ps2_rx_frontend: RTL
====================

PS2_RX_FRONTEND -- requirements
Module: ps2_rx_frontend

Interface
REQ-001 Parameter FILTER_CYCLES, default 8: number of consecutive identical clock samples needed before a new ps2_clk level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: number of clock cycles without an accepted ps2_clk falling edge, mid-frame, before the frame is aborted.
REQ-003 clock  input  1  system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous to clock.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous to clock.
REQ-007 ps2_key_pressed  output  1  one-cycle strobe marking a completed key event; it drives the processor's ps2_key_pressed input.
REQ-008 ps2_out  output  32  key event word; it drives the processor's ps2_out input.
REQ-009 frame_error  output  1  one-cycle strobe marking a rejected frame.

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The filtered clock SHALL change level only after the synchronized ps2_clk has held the new level for FILTER_CYCLES consecutive cycles.
REQ-012 An accepted falling edge is a filtered-clock transition from 1 to 0; the synchronized ps2_data SHALL be sampled in the same cycle the edge is detected.
REQ-013 The frame FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE -> DATA on an edge with data=0 (start bit); an edge with data=1 SHALL leave the FSM in IDLE with no error.
REQ-015 DATA SHALL shift in 8 bits, LSB first, then move to PARITY after the 8th edge; a 3-bit counter tracks the bit index.
REQ-016 PARITY SHALL capture one bit and move to STOP; the frame is good only if the 8 data bits plus the parity bit contain an odd number of 1s.
REQ-017 STOP SHALL capture one bit and return to IDLE; the frame is good only if the stop bit is 1 and parity passed.
REQ-018 A good byte equal to 0xF0 SHALL set break_flag and SHALL NOT strobe ps2_key_pressed.
REQ-019 A good byte equal to 0xE0 SHALL set ext_flag and SHALL NOT strobe ps2_key_pressed.
REQ-020 Any other good byte SHALL, in the cycle after the stop edge:
- load ps2_out = {22'b0, ext_flag, break_flag, byte};
- strobe ps2_key_pressed high for exactly one cycle;
- clear both flags.
REQ-021 ps2_out SHALL hold its last value until the next key event; it is never cleared except by reset.
REQ-022 A bad parity bit or a bad stop bit SHALL:
- strobe frame_error for one cycle, in the cycle after the stop edge;
- discard the byte;
- clear both flags;
- leave ps2_out unchanged.
REQ-023 Timeout: in DATA, PARITY or STOP, a 16-bit counter SHALL count the cycles since the last accepted edge.
- Reaching TIMEOUT_CYCLES SHALL force IDLE, strobe frame_error, and clear the bit counter and both flags.
- The counter SHALL be held at 0 while in IDLE.
REQ-024 An edge arriving in the same cycle the timeout fires SHALL be ignored; the timeout takes priority.
REQ-025 ps2_key_pressed and frame_error SHALL never both be high in the same cycle.
REQ-026 The worst-case latency from the stop-bit edge to the ps2_key_pressed strobe SHALL be 1 cycle (excluding synchronizer and filter delay).

Reset
REQ-027 While reset=0, asynchronously and regardless of clock:
- FSM = IDLE;
- ps2_key_pressed = 0, frame_error = 0, ps2_out = 0;
- both flags, the bit counter, the timeout counter and the filter counter = 0;
- filtered clock = 1 and synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no strobe on either output after release.
REQ-029 After reset is released, the first accepted edge SHALL require a genuine 1 -> 0 filtered-clock transition.

Verification
REQ-030 Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one ps2_key_pressed strobe, ps2_out=0x0000001C, frame_error stays 0.
REQ-031 Frames 0xF0 then 0x1C -> no strobe after the 0xF0 frame; one strobe after the 0x1C frame with ps2_out=0x0000011C.
REQ-032 Frames 0xE0, 0xF0, 0x75 -> a single strobe with ps2_out=0x00000375; a following plain 0x75 frame -> ps2_out=0x00000075.
REQ-033 Frame 0x1C with the parity bit flipped to 1 -> one frame_error strobe, no ps2_key_pressed strobe, ps2_out keeps its previous value.
REQ-034 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> one frame_error strobe, FSM in IDLE; a following good 0x29 frame -> ps2_out=0x00000029.
REQ-035 ps2_clk glitch low for 3 cycles during IDLE -> no state change; reset pulsed mid-frame -> outputs go to 0 at once, with no strobe afterwards.

Source files
------------

// File: rtl/ps2_rx_frontend.sv
// rtl/ps2_rx_frontend.sv - PS/2 keyboard receive front end: sync, clock filter, frame decode, make/break/extended tagging
module ps2_rx_frontend #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        ps2_key_pressed,
    output logic [31:0] ps2_out,
    output logic        frame_error
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2;
    logic          data_s1, data_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          timeout_fire;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic          ext_flag, break_flag;
    logic [15:0]   to_cnt;

    // Two-flop synchronizers for the raw keyboard lines; idle-high after reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Glitch filter: accept a new clock level only after it has been stable for FILTER_CYCLES samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            filt_prev <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Both the edge and the filter start high out of reset, so only a real 1->0 transition counts
    assign fall         = filt_prev & ~filt_clk;
    assign timeout_fire = (state != IDLE) && (to_cnt == TO_LAST);

    // Frame FSM with timeout watchdog; strobes and the key word are registered here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shift           <= '0;
            par_ok          <= 1'b0;
            ext_flag        <= 1'b0;
            break_flag      <= 1'b0;
            to_cnt          <= '0;
            ps2_key_pressed <= 1'b0;
            frame_error     <= 1'b0;
            ps2_out         <= '0;
        end else begin
            ps2_key_pressed <= 1'b0;
            frame_error     <= 1'b0;

            if (state == IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end

            if (timeout_fire) begin
                // Timeout wins over any edge arriving in the same cycle
                state       <= IDLE;
                frame_error <= 1'b1;
                bit_cnt     <= '0;
                ext_flag    <= 1'b0;
                break_flag  <= 1'b0;
                to_cnt      <= '0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_ok <= ^{data_s2, shift};
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s2 && par_ok) begin
                            if (shift == 8'hF0) begin
                                break_flag <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else begin
                                ps2_out         <= {22'b0, ext_flag, break_flag, shift};
                                ps2_key_pressed <= 1'b1;
                                ext_flag        <= 1'b0;
                                break_flag      <= 1'b0;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            ext_flag    <= 1'b0;
                            break_flag  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
